_demux8: RTL and testbench

Registered 1-to-8 stream demultiplexer with a valid/ready handshake on every port. It is the write-side counterpart of `_mux8`: it takes one `n`-bit word per cycle from a single producer and steers it, by a 3-bit select, into one of eight single-entry output holding registers. Each output drains to its own consumer independently. It sits between the CPU's result/writeback sources and per-destination consumers, such as register-file write ports and peripheral channels.

---
 rtl/_demux8.sv | 75 +++++++
 tb/tb__demux8.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/_demux8.sv
// Registered 1-to-8 valid/ready stream demultiplexer with eight single-entry holding registers.
// Optional accept counter enabled by defining DEMUX8_STATS_EN.
module _demux8 #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   sel,
  input  logic [n-1:0] in_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [n-1:0] out0,
  output logic [n-1:0] out1,
  output logic [n-1:0] out2,
  output logic [n-1:0] out3,
  output logic [n-1:0] out4,
  output logic [n-1:0] out5,
  output logic [n-1:0] out6,
  output logic [n-1:0] out7
`ifdef DEMUX8_STATS_EN
  ,
  output logic [15:0]  accept_count
`endif
);

  logic [7:0]   vld_p0;
  logic [n-1:0] dat_p0 [8];
  logic         accept;

  // A channel can take a word when empty or when its current word leaves this cycle.
  assign in_ready = rst_n & (~vld_p0[sel] | out_ready[sel]);
  assign accept   = in_valid & in_ready;

  // ---- stage p0: per-channel holding registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
      for (int k = 0; k < 8; k++) begin
        dat_p0[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (accept && (sel == 3'(k))) begin
          vld_p0[k] <= 1'b1;
          dat_p0[k] <= in_data;
        end else if (out_ready[k]) begin
          vld_p0[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX8_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count <= 16'd0;
    end else if (accept) begin
      accept_count <= accept_count + 16'd1;
    end
  end
`endif

  assign out_valid = vld_p0;
  assign out0      = dat_p0[0];
  assign out1      = dat_p0[1];
  assign out2      = dat_p0[2];
  assign out3      = dat_p0[3];
  assign out4      = dat_p0[4];
  assign out5      = dat_p0[5];
  assign out6      = dat_p0[6];
  assign out7      = dat_p0[7];

endmodule

// File: tb/tb__demux8.sv
// Scoreboard bench for _demux8: accepted words are queued and compared one edge later.
module tb__demux8;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   sel;
  logic [W-1:0] in_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
`ifdef DEMUX8_STATS_EN
  logic [15:0]  accept_count;
`endif
  logic [W-1:0] outs [8];

  typedef struct {
    int           ch;
    logic [W-1:0] d;
  } sb_t;
  sb_t sb_q[$];
  sb_t e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  _demux8 #(.n(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7)
`ifdef DEMUX8_STATS_EN
    , .accept_count(accept_count)
`endif
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; sel = 3'd5; in_data = 'hA5; out_ready = 8'h00;
    #2;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_out_valid got %h want 00", out_valid); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (outs[k] !== '0) begin n_fail++; $display("FAIL reset_out%0d got %h want 0", k, outs[k]); end
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    if (in_ready) sb_q.push_back('{5, 'hA5});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 8'h20) begin n_fail++; $display("FAIL reset_first_valid got %h want 20", out_valid); end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (outs[e.ch] !== e.d) begin n_fail++; $display("FAIL reset_first_data got %h want %h", outs[e.ch], e.d); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 8'h00; sel = 3'd2; in_data = 'h22; in_valid = 1'b1;
    #1;
    if (in_ready) sb_q.push_back('{2, 'h22});
    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (outs[e.ch] !== e.d || out_valid[e.ch] !== 1'b1) begin
        n_fail++; $display("FAIL bp_fill got %h/%b want %h/1", outs[e.ch], out_valid[e.ch], e.d);
      end
    end
    in_data = 'h33;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready cyc%0d got %b want 0", i, in_ready); end
      @(posedge clk); #1;
      n_checks++;
      if (out2 !== 'h22 || out_valid[2] !== 1'b1) begin
        n_fail++; $display("FAIL bp_stall_hold cyc%0d got %h/%b want 22/1", i, out2, out_valid[2]);
      end
    end
    out_ready[2] = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    if (in_ready) sb_q.push_back('{2, 'h33});
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (outs[e.ch] !== e.d || out_valid[e.ch] !== 1'b1) begin
        n_fail++; $display("FAIL bp_release_data got %h/%b want %h/1", outs[e.ch], out_valid[e.ch], e.d);
      end
    end
    @(posedge clk); #1;
    out_ready = 8'h00;
    n_checks++;
    if (out_valid !== 8'h20) begin n_fail++; $display("FAIL bp_drain got %h want 20", out_valid); end
  endtask

  task automatic test_streaming();
    int accepts = 0;
    out_ready = 8'h80; sel = 3'd7;
    for (int i = 0; i < 16; i++) begin
      in_data = W'(i); in_valid = 1'b1;
      #1;
      if (in_ready) begin accepts++; sb_q.push_back('{7, W'(i)}); end
      @(posedge clk); #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (outs[e.ch] !== e.d || out_valid[e.ch] !== 1'b1) begin
          n_fail++; $display("FAIL stream_word%0d got %h/%b want %h/1", i, outs[e.ch], out_valid[e.ch], e.d);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepts != 16) begin n_fail++; $display("FAIL stream_accepts got %0d want 16", accepts); end
    @(posedge clk); #1;
    out_ready = 8'h00;
    n_checks++;
    if (out_valid[7] !== 1'b0 || out7 !== 'd15) begin
      n_fail++; $display("FAIL stream_drain got %b/%h want 0/f", out_valid[7], out7);
    end
  endtask

  task automatic test_fanout();
    int chs [4] = '{0, 1, 3, 6};
    out_ready = 8'hFF;
    @(posedge clk); #1;
    out_ready = 8'h00;
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL fan_clear got %h want 00", out_valid); end
    for (int i = 0; i < 4; i++) begin
      sel = 3'(chs[i]); in_data = W'('h10 + chs[i]); in_valid = 1'b1;
      #1;
      if (in_ready) sb_q.push_back('{chs[i], W'('h10 + chs[i])});
      @(posedge clk); #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (outs[e.ch] !== e.d || out_valid[e.ch] !== 1'b1) begin
          n_fail++; $display("FAIL fan_fill ch%0d got %h/%b want %h/1", e.ch, outs[e.ch], out_valid[e.ch], e.d);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 8'h4B) begin n_fail++; $display("FAIL fan_full got %h want 4b", out_valid); end
    out_ready = 8'h4B;
    @(posedge clk); #1;
    out_ready = 8'h00;
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL fan_drain got %h want 00", out_valid); end
    n_checks++;
    if (out0 !== 'h10 || out1 !== 'h11 || out3 !== 'h13 || out6 !== 'h16 || out5 !== 'hA5) begin
      n_fail++; $display("FAIL fan_retain got %h %h %h %h %h want 10 11 13 16 a5", out0, out1, out3, out6, out5);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 8'h00;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k); in_data = W'('hC0 + k); in_valid = 1'b1;
      #1;
      if (in_ready) sb_q.push_back('{k, W'('hC0 + k)});
      @(posedge clk); #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (outs[e.ch] !== e.d || out_valid[e.ch] !== 1'b1) begin
          n_fail++; $display("FAIL stall_fill ch%0d got %h/%b want %h/1", e.ch, outs[e.ch], out_valid[e.ch], e.d);
        end
      end
    end
    sel = 3'd4;
    #1;
    n_checks++;
    if (out_valid !== 8'hFF || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_full got %h/%b want ff/0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 8'h00 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid got %h/%b want 00/0", out_valid, in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (outs[k] !== '0) begin n_fail++; $display("FAIL midrst_out%0d got %h want 0", k, outs[k]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 3'd3; in_data = 'h77; in_valid = 1'b1;
    #1;
    if (in_ready) sb_q.push_back('{3, 'h77});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL midrst_post_accept got none want 1");
    end else begin
      e = sb_q.pop_front();
      if (outs[e.ch] !== e.d || out_valid !== 8'h08) begin
        n_fail++; $display("FAIL midrst_post_accept got %h/%h want %h/08", outs[e.ch], out_valid, e.d);
      end
    end
  endtask

`ifdef DEMUX8_STATS_EN
  task automatic test_stats();
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_checks++;
    if (accept_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset got %h want 0", accept_count); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sel = 3'd0; out_ready = 8'h01; in_valid = 1'b1; in_data = 'h5;
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clk); #1;
      if (i == 65535) begin
        n_checks++;
        if (accept_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_ffff got %h want ffff", accept_count); end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (accept_count !== 16'd1) begin n_fail++; $display("FAIL stats_wrap got %h want 0001", accept_count); end
    out_ready = 8'h00; sel = 3'd2; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    n_checks++;
    if (accept_count !== 16'd2) begin n_fail++; $display("FAIL stats_stall got %h want 0002", accept_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_backpressure();
    test_streaming();
    test_fanout();
    test_reset_mid_stall();
`ifdef DEMUX8_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
